// File: rtl/pf_iod_dly_pkg.sv
// Shared types for the PF IOD dynamic delay-line tap controller.
// Holds the sequencer state encoding and the IOD direction-pin levels.
package pf_iod_dly_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETUP  = 3'd3,
    ST_MOVE   = 3'd4,
    ST_SETTLE = 3'd5,
    ST_FIN    = 3'd6
  } dly_state_e;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

endpackage

// File: rtl/pf_iod_dly_tap_ctrl.sv
// Sequences MOVE/DIRECTION/LOAD pulses on one PF IOD dynamic delay line,
// tracks the current tap and flags range saturation reported by the IOD.
module pf_iod_dly_tap_ctrl
  import pf_iod_dly_pkg::*;
#(
  parameter int TAP_W      = 8,
  parameter int MAX_TAP    = 255,
  parameter int LOAD_TAP   = 1,
  parameter int SETTLE_CYC = 3
) (
  input  logic             FAB_CLK,
  input  logic             ARST_N,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic             REQ_LOAD,
  input  logic [TAP_W-1:0] REQ_TAP,
  output logic             DONE,
  output logic             ERR_OOR,
  input  logic             ERR_CLR,
  output logic [TAP_W-1:0] CUR_TAP,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic             DELAY_LINE_LOAD,
  input  logic             DELAY_LINE_OUT_OF_RANGE
);

  localparam int               CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

  dly_state_e       r_state;
  dly_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [TAP_W-1:0] r_tgt;
  logic [TAP_W-1:0] r_cur_tap;
  logic             r_dir;
  logic             r_err;
  logic             r_after_load;
  logic             r_boot;
  logic             r_move;
  logic             r_load;
  logic             r_done;
  logic             r_ready;

  logic [TAP_W-1:0] w_req_tgt;
  logic             w_accept;
  logic             w_walk;
  logic             w_settle_end;
  logic             w_oor_hit;

  // Clamp in a one-bit-wider domain so the compare stays meaningful at full range.
  assign w_req_tgt    = ({1'b0, REQ_TAP} > (TAP_W + 1)'(MAX_TAP)) ? TAP_W'(MAX_TAP) : REQ_TAP;
  assign w_accept     = (r_state == ST_IDLE) && REQ_VALID;
  assign w_walk       = w_accept && !REQ_LOAD && (w_req_tgt != r_cur_tap);
  assign w_settle_end = (r_state == ST_SETTLE) && (r_cnt == CNT_LAST);
  assign w_oor_hit    = w_settle_end && !r_after_load && DELAY_LINE_OUT_OF_RANGE;

  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      ST_INIT:  w_state_nxt = ST_LOAD;
      ST_IDLE: begin
        if (w_accept) begin
          if (REQ_LOAD)                    w_state_nxt = ST_LOAD;
          else if (w_req_tgt == r_cur_tap) w_state_nxt = ST_FIN;
          else                             w_state_nxt = ST_SETUP;
        end
      end
      ST_LOAD:  w_state_nxt = ST_SETTLE;
      ST_SETUP: w_state_nxt = ST_MOVE;
      ST_MOVE:  w_state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (w_settle_end) begin
          if (w_oor_hit || r_after_load || (r_cur_tap == r_tgt)) w_state_nxt = ST_FIN;
          else                                                   w_state_nxt = ST_MOVE;
        end
      end
      ST_FIN:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_INIT;
    endcase
  end

  // Outputs are decoded from the next state so each one is a flop aligned with its state.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      r_state      <= ST_INIT;
      r_cnt        <= '0;
      r_tgt        <= '0;
      r_cur_tap    <= TAP_W'(LOAD_TAP);
      r_dir        <= DIR_DEC;
      r_err        <= 1'b0;
      r_after_load <= 1'b0;
      r_boot       <= 1'b1;
      r_move       <= 1'b0;
      r_load       <= 1'b0;
      r_done       <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere here so all flops update from pre-edge values.
      r_state <= w_state_nxt;
      r_move  <= (w_state_nxt == ST_MOVE);
      r_load  <= (w_state_nxt == ST_LOAD);
      r_ready <= (w_state_nxt == ST_IDLE);
      r_done  <= (w_state_nxt == ST_FIN) && !r_boot;

      if ((r_state == ST_SETTLE) && !w_settle_end) r_cnt <= r_cnt + CNT_W'(1);
      else                                         r_cnt <= '0;

      if (w_accept) r_tgt <= w_req_tgt;
      if (w_walk)   r_dir <= (w_req_tgt > r_cur_tap) ? DIR_INC : DIR_DEC;

      if (r_state == ST_MOVE)
        r_cur_tap <= (r_dir == DIR_INC) ? r_cur_tap + TAP_W'(1) : r_cur_tap - TAP_W'(1);
      else if (r_state == ST_LOAD)
        r_cur_tap <= TAP_W'(LOAD_TAP);
      else if (w_oor_hit)
        r_cur_tap <= (r_dir == DIR_INC) ? r_cur_tap - TAP_W'(1) : r_cur_tap + TAP_W'(1);

      if (r_state == ST_LOAD)      r_after_load <= 1'b1;
      else if (r_state == ST_MOVE) r_after_load <= 1'b0;

      if (r_state == ST_FIN) r_boot <= 1'b0;

      // A saturation report in the same cycle as a clear request keeps the flag set.
      if (w_oor_hit)                          r_err <= 1'b1;
      else if (ERR_CLR || r_state == ST_LOAD) r_err <= 1'b0;
    end
  end

  assign REQ_READY            = r_ready;
  assign DONE                 = r_done;
  assign ERR_OOR              = r_err;
  assign CUR_TAP              = r_cur_tap;
  assign DELAY_LINE_MOVE      = r_move;
  assign DELAY_LINE_DIRECTION = r_dir;
  assign DELAY_LINE_LOAD      = r_load;

  a_move_load_excl: assert property (@(posedge FAB_CLK) disable iff (!ARST_N)
    !(r_move && r_load));
  a_done_pulse: assert property (@(posedge FAB_CLK) disable iff (!ARST_N)
    r_done |=> !r_done);

endmodule

// File: tb/tb_pf_iod_dly_tap_ctrl.sv
// Directed bench for pf_iod_dly_tap_ctrl: boot load, walks up/down, saturation,
// error clear, zero-distance request, load request and reset mid-walk.
module tb_pf_iod_dly_tap_ctrl;

  logic       FAB_CLK = 1'b0;
  logic       ARST_N  = 1'b0;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic       REQ_LOAD = 1'b0;
  logic [7:0] REQ_TAP  = '0;
  logic       DONE;
  logic       ERR_OOR;
  logic       ERR_CLR = 1'b0;
  logic [7:0] CUR_TAP;
  logic       DELAY_LINE_MOVE;
  logic       DELAY_LINE_DIRECTION;
  logic       DELAY_LINE_LOAD;
  logic       DELAY_LINE_OUT_OF_RANGE = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  int mv_cyc[$];
  int mv_dir[$];
  int ld_cyc[$];
  int done_cyc;
  int n_done;
  int rdy_after;
  int n_overlap;

  pf_iod_dly_tap_ctrl #(
    .TAP_W(8), .MAX_TAP(255), .LOAD_TAP(1), .SETTLE_CYC(3)
  ) u_dut (
    .FAB_CLK                 (FAB_CLK),
    .ARST_N                  (ARST_N),
    .REQ_VALID               (REQ_VALID),
    .REQ_READY               (REQ_READY),
    .REQ_LOAD                (REQ_LOAD),
    .REQ_TAP                 (REQ_TAP),
    .DONE                    (DONE),
    .ERR_OOR                 (ERR_OOR),
    .ERR_CLR                 (ERR_CLR),
    .CUR_TAP                 (CUR_TAP),
    .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
    .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
    .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Releases reset at a falling edge (cycle 0) and watches the boot load sequence.
  task automatic boot_check(input string pfx);
    int ld_n = 0, ld_first = -1, rdy_first = -1, dn = 0;
    @(negedge FAB_CLK);
    ARST_N = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge FAB_CLK);
      if (DELAY_LINE_LOAD) begin ld_n++; if (ld_first < 0) ld_first = k; end
      if (DONE) dn++;
      if (REQ_READY && rdy_first < 0) rdy_first = k;
    end
    check({pfx, "_load_count"}, ld_n, 1);
    check({pfx, "_load_cycle"}, ld_first, 1);
    check({pfx, "_ready_cycle"}, rdy_first, 6);
    check({pfx, "_no_done"}, dn, 0);
    check({pfx, "_cur_tap"}, int'(CUR_TAP), 1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!REQ_READY && n < 40) begin
      @(negedge FAB_CLK);
      n++;
    end
    check("ready_wait", int'(REQ_READY), 1);
  endtask

  // Issues one request at a falling edge (cycle 0) and records pulses per cycle
  // until the cycle after DONE. oor_at>0 raises OUT_OF_RANGE after that MOVE.
  task automatic run_req(input bit ld, input int tap, input int oor_at);
    mv_cyc.delete(); mv_dir.delete(); ld_cyc.delete();
    done_cyc = -1; n_done = 0; rdy_after = 0; n_overlap = 0;
    wait_ready();
    REQ_VALID = 1'b1; REQ_LOAD = ld; REQ_TAP = 8'(tap);
    @(posedge FAB_CLK); #1;
    REQ_VALID = 1'b0; REQ_LOAD = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge FAB_CLK);
      if (done_cyc >= 0 && k == done_cyc + 1) begin
        rdy_after = int'(REQ_READY);
        DELAY_LINE_OUT_OF_RANGE = 1'b0;
        break;
      end
      if (DELAY_LINE_MOVE && DELAY_LINE_LOAD) n_overlap++;
      if (DELAY_LINE_MOVE) begin
        mv_cyc.push_back(k);
        mv_dir.push_back(int'(DELAY_LINE_DIRECTION));
        if (mv_cyc.size() == oor_at) DELAY_LINE_OUT_OF_RANGE = 1'b1;
      end
      if (DELAY_LINE_LOAD) ld_cyc.push_back(k);
      if (DONE) begin n_done++; if (done_cyc < 0) done_cyc = k; end
    end
    DELAY_LINE_OUT_OF_RANGE = 1'b0;
  endtask

  task automatic check_run(input string tag, input int moves, input int dir,
                           input int loads, input int dcyc, input int cur, input int err);
    check({tag, "_moves"}, mv_cyc.size(), moves);
    check({tag, "_loads"}, ld_cyc.size(), loads);
    check({tag, "_done_cycle"}, done_cyc, dcyc);
    check({tag, "_done_count"}, n_done, 1);
    check({tag, "_ready_after"}, rdy_after, 1);
    check({tag, "_overlap"}, n_overlap, 0);
    check({tag, "_cur_tap"}, int'(CUR_TAP), cur);
    check({tag, "_err"}, int'(ERR_OOR), err);
    if (moves > 0) check({tag, "_first_move"}, mv_cyc[0], 2);
    if (loads > 0) check({tag, "_load_cycle"}, ld_cyc[0], 1);
    for (int i = 0; i < mv_dir.size(); i++) check({tag, "_dir"}, mv_dir[i], dir);
    for (int i = 1; i < mv_cyc.size(); i++) check({tag, "_gap"}, mv_cyc[i] - mv_cyc[i-1], 4);
  endtask

  initial begin
    repeat (3) @(negedge FAB_CLK);
    check("rst_move", int'(DELAY_LINE_MOVE), 0);
    check("rst_load", int'(DELAY_LINE_LOAD), 0);
    check("rst_done", int'(DONE), 0);
    check("rst_ready", int'(REQ_READY), 0);
    check("rst_err", int'(ERR_OOR), 0);
    check("rst_dir", int'(DELAY_LINE_DIRECTION), 0);
    check("rst_cur_tap", int'(CUR_TAP), 1);

    boot_check("boot");

    // 1 -> 5: four increments, DONE at 4*(1+3)+2
    run_req(1'b0, 5, 0);
    check_run("up5", 4, 1, 0, 18, 5, 0);

    // 5 -> 2: three decrements
    run_req(1'b0, 2, 0);
    check_run("dn2", 3, 0, 0, 14, 2, 0);

    // Load ignores REQ_TAP
    run_req(1'b1, 200, 0);
    check_run("load", 0, 0, 1, 5, 1, 0);

    // 1 -> 10 with saturation reported after the 2nd MOVE
    run_req(1'b0, 10, 2);
    check_run("oor1", 2, 1, 0, 10, 2, 1);

    ERR_CLR = 1'b1;
    @(negedge FAB_CLK);
    ERR_CLR = 1'b0;
    check("err_clr", int'(ERR_OOR), 0);

    // Range flag while idle must not set the error
    DELAY_LINE_OUT_OF_RANGE = 1'b1;
    repeat (3) @(negedge FAB_CLK);
    DELAY_LINE_OUT_OF_RANGE = 1'b0;
    check("idle_oor_err", int'(ERR_OOR), 0);
    check("idle_oor_tap", int'(CUR_TAP), 2);

    // Zero-distance request
    run_req(1'b0, 2, 0);
    check_run("zero", 0, 0, 0, 1, 2, 0);

    // 2 -> 10 saturating after the 2nd MOVE, then a load clears the error
    run_req(1'b0, 10, 2);
    check_run("oor2", 2, 1, 0, 10, 3, 1);
    run_req(1'b1, 0, 0);
    check_run("load_err", 0, 0, 1, 5, 1, 0);

    // Reset in the middle of a 1 -> 20 walk
    begin
      int mv = 0;
      wait_ready();
      REQ_VALID = 1'b1; REQ_TAP = 8'd20;
      @(posedge FAB_CLK); #1;
      REQ_VALID = 1'b0;
      for (int k = 0; k < 30 && mv < 2; k++) begin
        @(negedge FAB_CLK);
        if (DELAY_LINE_MOVE) mv++;
      end
      check("mid_moves_seen", mv, 2);
      ARST_N = 1'b0;
      #1;
      check("mid_rst_move", int'(DELAY_LINE_MOVE), 0);
      check("mid_rst_dir", int'(DELAY_LINE_DIRECTION), 0);
      check("mid_rst_ready", int'(REQ_READY), 0);
      check("mid_rst_cur_tap", int'(CUR_TAP), 1);
      repeat (2) @(negedge FAB_CLK);
      check("mid_rst_done", int'(DONE), 0);
      boot_check("reboot");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
